// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame controller: FSM encoding, lane/word
// geometry and helpers for sizing beat counters from the FFT size.
package fft_pkg;

  // Controller phases: collecting a frame, streaming it out, holding off
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_BURST = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Four complex lanes per beat -> eight WIDTH-bit words per buffer row
  localparam int LANES          = 4;
  localparam int WORDS_PER_BEAT = 2 * LANES;

  // Default geometry for a 16-point FFT
  localparam int DEFAULT_SAMPLES = 16;
  localparam int DEFAULT_BEATS   = DEFAULT_SAMPLES / LANES;

  // Number of 4-lane beats that make up one frame
  function automatic int beats_of(input int samples);
    return samples / LANES;
  endfunction

  // Address width for a beat index; never narrower than one bit
  function automatic int addr_w(input int beats);
    if (beats <= 2) return 1;
    return $clog2(beats);
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Frame buffer: DEPTH rows of eight WIDTH-bit words, one synchronous write
// port and one combinational read port. Contents are never reset.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_BEATS,
  parameter int AW    = addr_w(DEFAULT_BEATS)
) (
  input  logic                              clock,
  input  logic                              we,
  input  logic [AW-1:0]                     waddr,
  input  logic [WORDS_PER_BEAT*WIDTH-1:0]   wdata,
  input  logic [AW-1:0]                     raddr,
  output logic [WORDS_PER_BEAT*WIDTH-1:0]   rdata
);

  logic [WORDS_PER_BEAT*WIDTH-1:0] mem [DEPTH];

  // Write one accepted beat into its row
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: gathers BEATS four-lane beats of a frame, bursts the
// frame into fft_top on consecutive cycles, and tracks how many frames are
// inside the FFT so that at most MAX_INFLIGHT are outstanding. Output beats
// from the FFT are tagged with first/last/frame id.
// Optional feature: define FFT_FRAME_CTRL_TIMEOUT_EN to add a watchdog that
// flags err_timeout and flushes the in-flight count when the FFT goes quiet.
//
// Handshake: a beat transfers on a rising clock edge where s_valid and
// s_ready are both high; s_valid may be raised or dropped freely and s_ready
// depends only on controller state, never on s_valid.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int Num_of_samples = 16,
  parameter int MAX_INFLIGHT   = 2,
  parameter int TIMEOUT        = 1024
) (
  input  logic             clock,
  input  logic             reset,
  // upstream beat interface
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_real_0,
  input  logic [WIDTH-1:0] s_real_1,
  input  logic [WIDTH-1:0] s_real_2,
  input  logic [WIDTH-1:0] s_real_3,
  input  logic [WIDTH-1:0] s_imag_0,
  input  logic [WIDTH-1:0] s_imag_1,
  input  logic [WIDTH-1:0] s_imag_2,
  input  logic [WIDTH-1:0] s_imag_3,
  // drive into fft_top
  output logic             fft_input_en,
  output logic [WIDTH-1:0] fft_real_0,
  output logic [WIDTH-1:0] fft_real_1,
  output logic [WIDTH-1:0] fft_real_2,
  output logic [WIDTH-1:0] fft_real_3,
  output logic [WIDTH-1:0] fft_imag_0,
  output logic [WIDTH-1:0] fft_imag_1,
  output logic [WIDTH-1:0] fft_imag_2,
  output logic [WIDTH-1:0] fft_imag_3,
  // fft_top output side
  input  logic             fft_output_en,
  output logic             m_valid,
  output logic             m_first,
  output logic             m_last,
  output logic [3:0]       m_frame_id,
  // status
  output logic [2:0]       inflight,
  output logic             busy,
  output logic             err_spurious,
  output logic             err_timeout,
  output state_t           dbg_state
);

  localparam int BEATS = beats_of(Num_of_samples);
  localparam int AW    = addr_w(BEATS);
  localparam int DW    = WORDS_PER_BEAT * WIDTH;

  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
  localparam logic [AW:0]   BURST_END = (AW+1)'(BEATS);
  localparam logic [2:0]    MAX3      = 3'(MAX_INFLIGHT);

  // Reject configurations the counters are not sized for
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 7 || TIMEOUT < 1 || BEATS < 2) begin : g_bad_params
    $error("fft_frame_ctrl: illegal parameter set");
  end

  state_t        state;
  logic [AW-1:0] fill_cnt;
  logic [AW:0]   burst_cnt;
  logic [AW-1:0] out_cnt;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] fft_word;

  logic beat_hs;
  logic burst_done;
  logic room_after_burst;
  logic out_beat;
  logic out_last;
  logic spurious;
  logic tmo_fire;

  // Lane k of a beat occupies word k (real) and word 4+k (imag)
  assign wr_word = {s_imag_3, s_imag_2, s_imag_1, s_imag_0,
                    s_real_3, s_real_2, s_real_1, s_real_0};

  fft_frame_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BEATS),
    .AW    (AW)
  ) u_buf (
    .clock (clock),
    .we    (beat_hs),
    .waddr (fill_cnt),
    .wdata (wr_word),
    .raddr (burst_cnt[AW-1:0]),
    .rdata (rd_word)
  );

  // Handshake and counter-event decode
  always_comb begin
    beat_hs          = s_valid && (state == ST_FILL);
    burst_done       = (state == ST_BURST) && (burst_cnt == BURST_END);
    room_after_burst = ({1'b0, inflight} + 4'd1) < {1'b0, MAX3};
    out_beat         = fft_output_en && (inflight != 3'd0);
    out_last         = out_beat && (out_cnt == LAST_BEAT);
    spurious         = fft_output_en && (inflight == 3'd0);
  end

  // Frame sequencing: fill the buffer, stream it to the FFT, then hold off
  // while the FFT already holds MAX_INFLIGHT frames
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_FILL;
      fill_cnt     <= '0;
      burst_cnt    <= '0;
      fft_input_en <= 1'b0;
      fft_word     <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          fft_input_en <= 1'b0;
          if (beat_hs) begin
            if (fill_cnt == LAST_BEAT) begin
              fill_cnt  <= '0;
              burst_cnt <= '0;
              state     <= ST_BURST;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (burst_cnt != BURST_END) begin
            // one buffer row per cycle, registered toward fft_top
            fft_input_en <= 1'b1;
            fft_word     <= rd_word;
            burst_cnt    <= burst_cnt + 1'b1;
          end else begin
            // last row is on the outputs now; the frame counts as in flight
            fft_input_en <= 1'b0;
            burst_cnt    <= '0;
            state        <= room_after_burst ? ST_FILL : ST_WAIT;
          end
        end
        ST_WAIT: begin
          fft_input_en <= 1'b0;
          if (inflight < MAX3) begin
            state <= ST_FILL;
          end
        end
        default: begin
          fft_input_en <= 1'b0;
          state        <= ST_FILL;
        end
      endcase
    end
  end

  // Output-side bookkeeping: beat position, frame id, in-flight count, spurious flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_cnt      <= '0;
      m_frame_id   <= 4'd0;
      inflight     <= 3'd0;
      err_spurious <= 1'b0;
    end else begin
      if (tmo_fire) begin
        inflight <= 3'd0;
        out_cnt  <= '0;
      end else begin
        inflight <= inflight + {2'b00, burst_done} - {2'b00, out_last};
        if (out_beat) begin
          out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        end
      end
      if (out_last) begin
        m_frame_id <= m_frame_id + 4'd1;
      end
      if (spurious) begin
        err_spurious <= 1'b1;
      end
    end
  end

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wd_cnt;
  logic           err_timeout_q;

  assign tmo_fire = (inflight != 3'd0) && !fft_output_en && (wd_cnt == WD_LAST);

  // Watchdog: count quiet cycles while frames are outstanding
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (inflight == 3'd0 || fft_output_en || tmo_fire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (tmo_fire) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign tmo_fire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign s_ready    = (state == ST_FILL);
  assign busy       = (state != ST_FILL) || (fill_cnt != '0) || (inflight != 3'd0);
  assign dbg_state  = state;

  // Output beat tagging follows fft_output_en in the same cycle
  assign m_valid = fft_output_en;
  assign m_first = fft_output_en && (out_cnt == '0);
  assign m_last  = fft_output_en && (out_cnt == LAST_BEAT);

  assign fft_real_0 = fft_word[0*WIDTH +: WIDTH];
  assign fft_real_1 = fft_word[1*WIDTH +: WIDTH];
  assign fft_real_2 = fft_word[2*WIDTH +: WIDTH];
  assign fft_real_3 = fft_word[3*WIDTH +: WIDTH];
  assign fft_imag_0 = fft_word[4*WIDTH +: WIDTH];
  assign fft_imag_1 = fft_word[5*WIDTH +: WIDTH];
  assign fft_imag_2 = fft_word[6*WIDTH +: WIDTH];
  assign fft_imag_3 = fft_word[7*WIDTH +: WIDTH];

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl (16-point FFT, MAX_INFLIGHT=1, TIMEOUT=16).
// The reference keeps accepted beats in a queue and predicts the burst window
// from the cycle the frame completed; directed scenarios add literal checks.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int W     = 32;
  localparam int NS    = 16;
  localparam int BEATS = 4;
  localparam int MAXI  = 1;
  localparam int TMO   = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  sr [4];
  logic [W-1:0]  si [4];
  logic          fft_input_en;
  logic [W-1:0]  fr [4];
  logic [W-1:0]  fi [4];
  logic          fft_output_en = 1'b0;
  logic          m_valid, m_first, m_last;
  logic [3:0]    m_frame_id;
  logic [2:0]    inflight;
  logic          busy, err_spurious, err_timeout;
  state_t        dbg_state;

  initial begin
    for (int k = 0; k < 4; k++) begin
      sr[k] = '0;
      si[k] = '0;
    end
  end

  fft_frame_ctrl #(
    .WIDTH(W), .Num_of_samples(NS), .MAX_INFLIGHT(MAXI), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_real_0(sr[0]), .s_real_1(sr[1]), .s_real_2(sr[2]), .s_real_3(sr[3]),
    .s_imag_0(si[0]), .s_imag_1(si[1]), .s_imag_2(si[2]), .s_imag_3(si[3]),
    .fft_input_en(fft_input_en),
    .fft_real_0(fr[0]), .fft_real_1(fr[1]), .fft_real_2(fr[2]), .fft_real_3(fr[3]),
    .fft_imag_0(fi[0]), .fft_imag_1(fi[1]), .fft_imag_2(fi[2]), .fft_imag_3(fi[3]),
    .fft_output_en(fft_output_en),
    .m_valid(m_valid), .m_first(m_first), .m_last(m_last), .m_frame_id(m_frame_id),
    .inflight(inflight), .busy(busy),
    .err_spurious(err_spurious), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // sample index idx of frame f
  function automatic logic [W-1:0] re_val(input int f, input int idx);
    return 32'h1000 + 32'(f * 64 + idx);
  endfunction
  function automatic logic [W-1:0] im_val(input int f, input int idx);
    return 32'h2000 + 32'(f * 64 + idx);
  endfunction

  // ---------------- reference model ----------------
  // m_mode: 0 accepting beats, 1 frame scheduled for burst, 2 held off
  int                  m_mode, m_t0, m_inf, m_out, m_fid, m_wd;
  bit                  m_spur, m_tmo;
  logic [8*W-1:0]      m_exp_q [$];
  logic [8*W-1:0]      m_frame [BEATS];
  logic [8*W-1:0]      m_hold;

  // burst log read by directed checks
  int                  en_count, en_first, en_last;
  logic [W-1:0]        first_r0, first_r1, last_i3;

  task automatic model_reset();
    m_mode = 0; m_t0 = 0; m_inf = 0; m_out = 0; m_fid = 0; m_wd = 0;
    m_spur = 0; m_tmo = 0; m_hold = '0;
    m_exp_q.delete();
  endtask

  initial model_reset();

  // Compare process: every cycle out of reset, on the falling edge
  always @(negedge clock) begin
    bit exp_en;
    int inc, dec, nmode;
    bit fire;
    if (reset) begin
      model_reset();
    end else begin
      exp_en = (m_mode == 1) && (cyc >= m_t0) && (cyc < m_t0 + BEATS);
      if (exp_en) m_hold = m_frame[cyc - m_t0];
      chk("s_ready", s_ready, m_mode == 0);
      chk("fft_input_en", fft_input_en, exp_en);
      for (int k = 0; k < 4; k++) begin
        chk("fft_real", fr[k], m_hold[k*W +: W]);
        chk("fft_imag", fi[k], m_hold[(4+k)*W +: W]);
      end
      chk("m_valid", m_valid, fft_output_en);
      if (fft_output_en && m_inf > 0) begin
        chk("m_first", m_first, m_out == 0);
        chk("m_last", m_last, m_out == BEATS - 1);
      end
      chk("m_frame_id", m_frame_id, m_fid);
      chk("inflight", inflight, m_inf);
      chk("busy", busy, (m_mode != 0) || (m_exp_q.size() != 0) || (m_inf != 0));
      chk("err_spurious", err_spurious, m_spur);
      chk("err_timeout", err_timeout, m_tmo);

      if (fft_input_en) begin
        if (en_count == 0) begin
          en_first = cyc;
          first_r0 = fr[0];
          first_r1 = fr[1];
        end
        en_last = cyc;
        last_i3 = fi[3];
        en_count++;
      end

      // advance the model by one cycle
      inc = (m_mode == 1 && cyc == m_t0 + BEATS - 1) ? 1 : 0;
      dec = 0;
      fire = 0;
      nmode = m_mode;
      if (m_mode == 0 && s_valid) begin
        m_exp_q.push_back({si[3], si[2], si[1], si[0], sr[3], sr[2], sr[1], sr[0]});
        if (m_exp_q.size() == BEATS) begin
          for (int b = 0; b < BEATS; b++) m_frame[b] = m_exp_q[b];
          m_exp_q.delete();
          m_t0 = cyc + 2;
          nmode = 1;
        end
      end
      if (inc != 0) nmode = (m_inf + 1 < MAXI) ? 0 : 2;
      if (m_mode == 2 && m_inf < MAXI) nmode = 0;
      if (fft_output_en) begin
        if (m_inf == 0) m_spur = 1;
        else if (m_out == BEATS - 1) begin
          m_out = 0;
          dec = 1;
          m_fid = (m_fid + 1) % 16;
        end else m_out++;
      end
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
      if (m_inf > 0 && !fft_output_en) begin
        if (m_wd == TMO - 1) begin
          fire = 1;
          m_wd = 0;
        end else m_wd++;
      end else m_wd = 0;
`endif
      if (fire) begin
        m_tmo = 1;
        m_inf = 0;
        m_out = 0;
      end else m_inf = m_inf + inc - dec;
      m_mode = nmode;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input int f, input int b, output int hs_cyc);
    bit acc;
    acc = 0;
    hs_cyc = -1;
    for (int k = 0; k < 4; k++) begin
      sr[k] = re_val(f, b + k * BEATS);
      si[k] = im_val(f, b + k * BEATS);
    end
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clock);
      acc = s_ready;
      hs_cyc = cyc;
      step();
    end
    s_valid = 1'b0;
    chk("handshake", acc, 1);
  endtask

  task automatic send_frame(input int f, input bit gap, output int h0);
    int hs;
    h0 = -1;
    for (int b = 0; b < BEATS; b++) begin
      send_beat(f, b, hs);
      if (b == 0) h0 = hs;
      if (gap) step();
    end
  endtask

  // drive BEATS consecutive output strobes and pin the tagging
  task automatic out_frame(input int fid);
    for (int i = 0; i < BEATS; i++) begin
      fft_output_en = 1'b1;
      @(negedge clock);
      chk("lit_m_first", m_first, i == 0);
      chk("lit_m_last", m_last, i == BEATS - 1);
      chk("lit_frame_id", m_frame_id, fid);
      chk("lit_ready_blocked", s_ready, 0);
      step();
    end
    fft_output_en = 1'b0;
  endtask

  task automatic wait_inflight(input int v, input int budget);
    bit hit;
    hit = 0;
    for (int t = 0; t < budget && !hit; t++) begin
      @(negedge clock);
      hit = (inflight == 3'(v));
      step();
    end
    chk("wait_inflight", hit, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int h0, h1, k;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_input_en", fft_input_en, 0);
    chk("rst_frame_id", m_frame_id, 0);
    chk("rst_err_spurious", err_spurious, 0);
    step();

    // spurious output strobe with nothing in flight
    fft_output_en = 1'b1;
    step();
    fft_output_en = 1'b0;
    @(negedge clock);
    chk("spur_flag", err_spurious, 1);
    chk("spur_frame_id", m_frame_id, 0);
    chk("spur_inflight", inflight, 0);
    step();
    repeat (3) step();
    @(negedge clock);
    chk("spur_sticky", err_spurious, 1);
    pulse_reset();
    @(negedge clock);
    chk("spur_cleared", err_spurious, 0);
    step();

    // frame 0, back-to-back beats
    en_count = 0;
    send_frame(0, 0, h0);
    while (cyc < h0 + 10) step();
    @(negedge clock);
    chk("f0_en_first", en_first - h0, 5);
    chk("f0_en_last", en_last - h0, 8);
    chk("f0_en_count", en_count, 4);
    chk("f0_real0", first_r0, 32'h1000);
    chk("f0_real1", first_r1, 32'h1004);
    chk("f0_imag3_last", last_i3, 32'h200F);
    chk("f0_inflight", inflight, 1);
    chk("f0_blocked", s_ready, 0);
    step();

    // second frame offered while the first is in flight; s_valid toggles
    en_count = 0;
    fork
      send_frame(1, 1, h1);
      out_frame(0);
    join
    wait_inflight(1, 60);
    chk("f1_en_count", en_count, 4);
    chk("f1_contiguous", en_last - en_first, 3);
    chk("f1_real0", first_r0, 32'h1040);
    chk("f1_imag3_last", last_i3, 32'h204F);
    out_frame(1);
    @(negedge clock);
    chk("f1_frame_id_after", m_frame_id, 2);
    chk("f1_inflight_after", inflight, 0);
    step();

    // reset in the middle of a burst
    send_frame(2, 0, h0);
    k = 0;
    for (int t = 0; t < 20 && k < 2; t++) begin
      step();
      if (fft_input_en) k++;
    end
    chk("mid_burst_seen", k, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_input_en", fft_input_en, 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_frame_id", m_frame_id, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_real0", fr[0], 0);
    step();

    // frame left in the FFT with no output strobes
    send_frame(3, 0, h0);
    wait_inflight(1, 40);
    @(negedge clock);
    chk("idle_no_timeout_yet", err_timeout, 0);
    step();
    repeat (20) step();
    @(negedge clock);
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_inflight", inflight, 0);
`else
    chk("no_wd_flag", err_timeout, 0);
    chk("no_wd_inflight", inflight, 1);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
    $fatal(1, "time limit");
  end

endmodule
